// File: rtl/axis_frame_sequencer.sv
// axis_frame_sequencer
// Sits between a free-running AXI-Stream test source and a DMA S2MM input.
// It gates the source handshake, splits the stream into frames of a
// programmed beat length with a locally generated tlast, and inserts an idle
// gap between frames. It stops after a programmed frame count, or at the next
// frame boundary when stop is requested.
//
// Optional feature macro: AXIS_SEQ_TLAST_CHECK_EN
//   When defined, every RUN handshake compares the source tlast with the
//   generated tlast. Any mismatch sets a sticky err flag, which is cleared by
//   the next accepted start or by reset. Without the macro, err is tied to 0
//   and no compare logic is built.

module axis_frame_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 1,
    parameter int LEN_WIDTH  = 16,
    parameter int FRM_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [FRM_WIDTH-1:0]  cfg_num_frames,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,

    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,

    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,

    output logic                  busy,
    output logic                  done,
    output logic [FRM_WIDTH-1:0]  frame_cnt,
    output logic                  err
);

    // Width-exact constants. These keep the counter arithmetic free of
    // implicit width extension.
    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [FRM_WIDTH-1:0] FRM_ZERO = '0;
    localparam logic [FRM_WIDTH-1:0] FRM_ONE  = FRM_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ZERO = '0;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE  = GAP_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and shadow configuration
    // ------------------------------------------------------------------
    state_t               state_q;
    logic [LEN_WIDTH-1:0] last_beat_q;   // index of the tlast beat (len-1, len=0 -> 0)
    logic [FRM_WIDTH-1:0] num_frames_q;  // 0 = continuous
    logic [GAP_WIDTH-1:0] gap_q;
    logic [LEN_WIDTH-1:0] beat_cnt_q;
    logic [FRM_WIDTH-1:0] frame_cnt_q;
    logic [GAP_WIDTH-1:0] gap_cnt_q;
    logic                 stop_pend_q;
    logic                 done_q;

    // Next-value helpers
    logic [LEN_WIDTH-1:0] last_beat_d;
    logic [LEN_WIDTH-1:0] beat_cnt_d;
    logic [FRM_WIDTH-1:0] frame_cnt_d;
    logic [GAP_WIDTH-1:0] gap_cnt_d;

    // Datapath qualifiers
    logic in_run;
    logic tlast_gen;
    logic beat_hs;
    logic count_reached;
    logic stop_now;

    // Compute counter increments and frame-boundary qualifiers.
    always_comb begin
        last_beat_d   = (cfg_frame_len == LEN_ZERO) ? LEN_ZERO
                                                    : (cfg_frame_len - LEN_ONE);
        beat_cnt_d    = beat_cnt_q + LEN_ONE;
        frame_cnt_d   = frame_cnt_q + FRM_ONE;
        gap_cnt_d     = gap_cnt_q - GAP_ONE;
        in_run        = (state_q == S_RUN);
        tlast_gen     = in_run && (beat_cnt_q == last_beat_q);
        beat_hs       = in_run && s_axis_tvalid && m_axis_tready;
        count_reached = (num_frames_q != FRM_ZERO) && (frame_cnt_d == num_frames_q);
        // A stop arriving with the final beat of a frame ends the run there.
        stop_now      = stop_pend_q || stop;
    end

    // ------------------------------------------------------------------
    // Stream path: zero latency. Handshakes pass only while in RUN, so the
    // source holds its data in IDLE and GAP.
    // ------------------------------------------------------------------
    assign m_axis_tvalid = in_run && s_axis_tvalid;
    assign s_axis_tready = in_run && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = tlast_gen;

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

    // Sequencer FSM: handles start/stop control, beat and frame counting,
    // and the inter-frame gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_beat_q  <= LEN_ZERO;
            num_frames_q <= FRM_ZERO;
            gap_q        <= GAP_ZERO;
            beat_cnt_q   <= LEN_ZERO;
            frame_cnt_q  <= FRM_ZERO;
            gap_cnt_q    <= GAP_ZERO;
            stop_pend_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // stop is ignored here. A coincident start wins.
                    if (start) begin
                        last_beat_q  <= last_beat_d;
                        num_frames_q <= cfg_num_frames;
                        gap_q        <= cfg_gap;
                        beat_cnt_q   <= LEN_ZERO;
                        frame_cnt_q  <= FRM_ZERO;
                        gap_cnt_q    <= GAP_ZERO;
                        stop_pend_q  <= 1'b0;
                        state_q      <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (beat_hs) begin
                        if (tlast_gen) begin
                            beat_cnt_q  <= LEN_ZERO;
                            frame_cnt_q <= frame_cnt_d;
                            if (count_reached || stop_now) begin
                                state_q     <= S_IDLE;
                                done_q      <= 1'b1;
                                stop_pend_q <= 1'b0;
                            end else if (gap_q == GAP_ZERO) begin
                                state_q <= S_RUN;
                            end else begin
                                gap_cnt_q <= gap_q;
                                state_q   <= S_GAP;
                            end
                        end else begin
                            beat_cnt_q <= beat_cnt_d;
                        end
                    end
                end

                S_GAP: begin
                    // Between frames, a stop takes effect at once.
                    if (stop) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (gap_cnt_q == GAP_ONE) begin
                        state_q <= S_RUN;
                    end else begin
                        gap_cnt_q <= gap_cnt_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef AXIS_SEQ_TLAST_CHECK_EN
    logic err_q;

    // Sticky flag set when the source frame boundary disagrees with ours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            err_q <= 1'b0;
        end else if (beat_hs && (s_axis_tlast != tlast_gen)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // The source tlast is not used when the checker is absent.
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis_tlast;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Self-checking bench for axis_frame_sequencer.
// The stimulus process pushes the expected beats and done events into
// queues. A monitor samples just before each rising edge, pops the queues
// and compares them against the DUT.
`timescale 1ns/1ps

module tb_axis_frame_sequencer;

    localparam int DW = 32;
    localparam int KW = 1;
    localparam int LW = 16;
    localparam int FW = 16;
    localparam int GW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop;
    logic [LW-1:0] cfg_frame_len;
    logic [FW-1:0] cfg_num_frames;
    logic [GW-1:0] cfg_gap;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          busy, done, err;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    axis_frame_sequencer #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW),
        .FRM_WIDTH(FW), .GAP_WIDTH(GW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames), .cfg_gap(cfg_gap),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .frame_cnt(frame_cnt), .err(err)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t       exp_q[$];
    logic [FW-1:0] exp_done_q[$];
    int          beat_cyc[$];
    int          cyc        = 0;
    int          hs_count   = 0;
    int          done_count = 0;
    int          done_cyc   = 0;
    int          n_vec      = 0;
    int          n_err      = 0;

    int          src_cnt      = 0;
    int          last_per     = 0;
    int          last_base    = 0;
    bit          ready_toggle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Source counter generator and sink ready pattern. Inputs change 1 ns
    // after each rising edge.
    initial begin
        bit src_hs;
        forever begin
            @(negedge clk);
            #4;
            src_hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (src_hs) src_cnt++;
            s_axis_tdata = src_cnt;
            s_axis_tkeep = KW'(src_cnt & 1);
            s_axis_tlast = (last_per != 0) && (((src_cnt - last_base) % last_per) == last_per - 1);
            if (ready_toggle) m_axis_tready = ~m_axis_tready;
            else              m_axis_tready = 1'b1;
        end
    end

    // Monitor: samples 1 ns before each rising edge and scores beats and done pulses.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst && m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_beat: got data %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_axis_tdata), 64'(e.data));
                    chk("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
                    chk("beat_tlast", 64'(m_axis_tlast), 64'(e.last));
                end
            end
            if (!rst && done) begin
                done_count++;
                done_cyc = cyc;
                if (exp_done_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    chk("done_frame_cnt", 64'(frame_cnt), 64'(exp_done_q.pop_front()));
                    chk("done_busy_low", 64'(busy), 64'd0);
                end
            end
        end
    end

    task automatic push_beats(input int base, input int nbeats, input int len);
        int  leff;
        beat_t b;
        leff = (len == 0) ? 1 : len;
        for (int i = 0; i < nbeats; i++) begin
            b.data = DW'(base + i);
            b.keep = KW'((base + i) & 1);
            b.last = ((i % leff) == leff - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_start(input int len, input int num, input int gap);
        cfg_frame_len  = LW'(len);
        cfg_num_frames = FW'(num);
        cfg_gap        = GW'(gap);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int k = 0;
        while (hs_count < target && k < budget) begin tick(); k++; end
        if (hs_count < target) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", name, hs_count, target);
        end
    endtask

    task automatic wait_done(input int prev, input int budget, input string name);
        int k = 0;
        while (done_count == prev && k < budget) begin tick(); k++; end
        if (done_count == prev) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: got no done expected done pulse", name);
        end
    endtask

    function automatic int bc(input int idx);
        return (idx < beat_cyc.size()) ? beat_cyc[idx] : -1000;
    endfunction

    // Directed test sequence
    initial begin
        int b0, h0, d0, highs;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_frame_len = '0; cfg_num_frames = '0; cfg_gap = '0;
        s_axis_tvalid = 1'b1; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        rst = 1'b0;
        tick();

        // T1: len=4 num=3 gap=2; a start while busy must be ignored
        b0 = beat_cyc.size(); h0 = hs_count; d0 = done_count;
        push_beats(src_cnt, 12, 4);
        exp_done_q.push_back(FW'(3));
        run_start(4, 3, 2);
        wait_beats(h0 + 5, 50, "t1_beats");
        cfg_frame_len = LW'(7); start = 1'b1; tick(); start = 1'b0;
        wait_done(d0, 100, "t1_done");
        chk("t1_back_to_back", 64'(bc(b0 + 1) - bc(b0)), 64'd1);
        chk("t1_gap1", 64'(bc(b0 + 4) - bc(b0 + 3)), 64'd3);
        chk("t1_gap2", 64'(bc(b0 + 8) - bc(b0 + 7)), 64'd3);
        chk("t1_done_latency", 64'(done_cyc - bc(b0 + 11)), 64'd1);
        tick();
        chk("t1_frame_cnt_hold", 64'(frame_cnt), 64'd3);

        // T2: len=0 (treated as 1), num=2, gap=0
        b0 = beat_cyc.size(); d0 = done_count;
        push_beats(src_cnt, 2, 0);
        exp_done_q.push_back(FW'(2));
        run_start(0, 2, 0);
        wait_done(d0, 50, "t2_done");
        chk("t2_back_to_back", 64'(bc(b0 + 1) - bc(b0)), 64'd1);
        chk("t2_done_latency", 64'(done_cyc - bc(b0 + 1)), 64'd1);

        // T3: continuous, len=8, toggling ready, stop mid frame 5
        b0 = beat_cyc.size(); h0 = hs_count; d0 = done_count;
        ready_toggle = 1'b1;
        push_beats(src_cnt, 40, 8);
        exp_done_q.push_back(FW'(5));
        run_start(8, 0, 0);
        wait_beats(h0 + 34, 200, "t3_beats");
        stop = 1'b1; tick(); stop = 1'b0;
        wait_done(d0, 100, "t3_done");
        ready_toggle = 1'b0;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (s_axis_tready) highs++;
        end
        chk("t3_no_tready_after_stop", 64'(highs), 64'd0);
        chk("t3_frame_cnt", 64'(frame_cnt), 64'd5);

        // T4: stop during gap (len=2, gap=10, stop in gap cycle 3)
        b0 = beat_cyc.size(); h0 = hs_count; d0 = done_count;
        push_beats(src_cnt, 2, 2);
        exp_done_q.push_back(FW'(1));
        run_start(2, 0, 10);
        wait_beats(h0 + 2, 50, "t4_beats");
        tick(); tick();
        chk("t4_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t4_gap_tready", 64'(s_axis_tready), 64'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        wait_done(d0, 50, "t4_done");
        chk("t4_stop_latency", 64'(done_cyc - bc(b0 + 1)), 64'd4);

        // T5: reset on beat 2 of a 4-beat frame, then a clean restart
        h0 = hs_count;
        push_beats(src_cnt, 4, 4);
        run_start(4, 1, 0);
        wait_beats(h0 + 2, 50, "t5_beats");
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t5_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("t5_rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t5_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t5_dropped_beats", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
        d0 = done_count;
        push_beats(src_cnt, 4, 4);
        exp_done_q.push_back(FW'(1));
        run_start(4, 1, 0);
        wait_done(d0, 50, "t5_done");

`ifdef AXIS_SEQ_TLAST_CHECK_EN
        // T6: source tlast every 511 beats against len=512
        h0 = hs_count; d0 = done_count;
        last_base = src_cnt;
        last_per  = 511;
        tick();
        push_beats(src_cnt, 512, 512);
        exp_done_q.push_back(FW'(1));
        run_start(512, 1, 0);
        chk("t6_err_clear_at_start", 64'(err), 64'd0);
        wait_beats(h0 + 510, 1000, "t6_beats_a");
        chk("t6_err_before_511", 64'(err), 64'd0);
        wait_beats(h0 + 511, 20, "t6_beats_b");
        chk("t6_err_after_511", 64'(err), 64'd1);
        wait_done(d0, 50, "t6_done");
        chk("t6_err_sticky", 64'(err), 64'd1);
        last_per = 0;
        tick();
        d0 = done_count;
        push_beats(src_cnt, 1, 1);
        exp_done_q.push_back(FW'(1));
        run_start(1, 1, 0);
        chk("t6_err_cleared_by_start", 64'(err), 64'd0);
        wait_done(d0, 50, "t6b_done");
`else
        chk("err_tied_low", 64'(err), 64'd0);
`endif

        tick(); tick();
        chk("beats_all_seen", 64'(exp_q.size()), 64'd0);
        chk("dones_all_seen", 64'(exp_done_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/axis_frame_sequencer.md
# axis_frame_sequencer

Controller placed between an AXI-Stream test source (free-running counter generator) and the DMA S2MM stream input. Gates the source handshake, cuts the stream into frames of a programmed beat length with its own `tlast`, inserts a programmable idle gap between frames and stops after a programmed frame count or on request. Software-visible control and status come from the AXI-Lite register block.

## Interface
- `DATA_WIDTH`, 32, stream data width in bits.
- `KEEP_WIDTH`, 1, stream `tkeep` width.
- `LEN_WIDTH`, 16, width of the frame length and beat counter.
- `FRM_WIDTH`, 16, width of the frame count and frame counter.
- `GAP_WIDTH`, 8, width of the inter-frame gap counter.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms the sequencer and latches config.
- `stop`  in  1  one-cycle pulse; graceful stop at the next frame boundary.
- `cfg_frame_len`  in  LEN_WIDTH  beats per frame; 0 is treated as 1.
- `cfg_num_frames`  in  FRM_WIDTH  frames to send; 0 means continuous until `stop`.
- `cfg_gap`  in  GAP_WIDTH  idle cycles between frames.
- `s_axis_tvalid`/`s_axis_tready`/`s_axis_tdata`/`s_axis_tkeep`/`s_axis_tlast`  in/out/in/in/in  1/1/DATA_WIDTH/KEEP_WIDTH/1  from the source.
- `m_axis_tvalid`/`m_axis_tready`/`m_axis_tdata`/`m_axis_tkeep`/`m_axis_tlast`  out/in/out/out/out  1/1/DATA_WIDTH/KEEP_WIDTH/1  to the DMA.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on return to IDLE.
- `frame_cnt`  out  FRM_WIDTH  frames completed since the last accepted `start`.
- `err`  out  1  sticky tlast-mismatch flag (only with the macro; otherwise tied 0).

## Operation
- States: IDLE, RUN, GAP.
- IDLE + `start`:
  - latch `cfg_*` into shadow registers;
  - clear the beat counter, `frame_cnt`, stop-pending and `err`;
  - go to RUN.
- `start` while busy is ignored. `cfg_*` changes are invisible until the next accepted `start`.
- RUN: `m_axis_tvalid = s_axis_tvalid`, `s_axis_tready = m_axis_tready`.
  - `m_axis_tdata`/`tkeep` pass through combinationally.
  - `m_axis_tlast = (beat_cnt == len-1)`.
  - The beat counter increments on each `m_axis_tvalid && m_axis_tready`.
- Frame end = handshake with `m_axis_tlast` high. On frame end:
  - clear `beat_cnt` and increment `frame_cnt`, which wraps at 2^FRM_WIDTH;
  - if `num_frames != 0` and `frame_cnt+1 == num_frames`, or stop is pending: go to IDLE and pulse `done`;
  - else if `gap == 0`: stay in RUN;
  - else: go to GAP and load the gap counter with `gap`.
- GAP: both `tvalid`/`tready` are forced 0. The counter decrements each cycle; on reaching 1 go to RUN. The gap is exactly `gap` idle cycles.
- `stop` in RUN sets stop-pending; the current frame completes in full.
- `stop` in GAP goes straight to IDLE with a `done` pulse.
- `stop` in IDLE is ignored. If `start` and `stop` arrive in the same IDLE cycle, `start` is taken and `stop` is dropped.
- In IDLE and GAP, `m_axis_tvalid = 0` and `s_axis_tready = 0`, so the source holds.
- `s_axis_tlast` is not forwarded; only the sequencer's own `tlast` appears downstream.

## Timing
- Data path latency is 0 cycles, with no buffering. `m_axis_tready` to `s_axis_tready` is combinational, gated by the registered state.
- `busy` rises the cycle after `start`. The first beat can transfer in that same cycle.
- `done` is asserted in the cycle after the final handshake, with `busy` low in that cycle.
- Reset values: state IDLE, `busy=0`, `done=0`, `frame_cnt=0`, `err=0`, `m_axis_tvalid=0`, `m_axis_tlast=0`, `s_axis_tready=0`.
- Reset asserted mid-frame drops the frame immediately; no `tlast` is emitted for it.
- A `m_axis_tvalid` stall with `tready` high, or the reverse, holds all counters.

## Configuration
- `AXIS_SEQ_TLAST_CHECK_EN`:
  - when defined, every RUN handshake compares `s_axis_tlast` with the generated `m_axis_tlast`;
  - any mismatch sets `err`, which stays set until the next accepted `start` or reset;
  - streaming is not altered.
- Without the macro, `err` is constant 0 and no compare logic exists.

## Test plan
- len=4, num=3, gap=2, sink always ready, source always valid -> 12 beats; `tlast` on beats 4/8/12; 2 idle cycles after frames 1 and 2; `done` 1 cycle after beat 12; `frame_cnt=3`.
- len=0, num=2, gap=0 -> 2 beats, both with `tlast`, back-to-back; `done` after beat 2.
- num=0, len=8, sink toggling ready every other cycle; `stop` on beat 3 of frame 5 -> frame 5 completes (8 beats, `tlast` on the 8th); `done`; `frame_cnt=5`; no further `s_axis_tready`.
- `stop` during GAP (len=2, gap=10, `stop` at gap cycle 3) -> immediate IDLE, `done` pulse, `frame_cnt=1`.
- `rst` asserted on beat 2 of a len=4 frame -> all outputs at reset values the same cycle. A new `start` then yields a full 4-beat frame from beat 0.
- With `AXIS_SEQ_TLAST_CHECK_EN`: source `tlast` every 511 beats, len=512 -> `err=1` after beat 511, data still streams, `err` cleared by the next `start`.
